// File: rtl/ama_riscv_fetch_unit.sv
// Instruction fetch unit: PC generation, IMEM request/response tracking and a
// small fetch queue feeding ID, with redirect squashing of in-flight responses.
module ama_riscv_fetch_unit #(
   parameter logic [31:0] RESET_VEC = 32'h0,
   parameter int          AW        = 14,
   parameter int          FQ_DEPTH  = 4,
   parameter logic [31:0] NOP_INST  = 32'h0000_0013
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [1:0]    pc_sel,
   input  logic [31:0]   alu_out,
   input  logic [31:0]   bp_target,
   input  logic          stall_id,
   output logic          imem_req,
   output logic [AW-1:0] imem_addr,
   input  logic          imem_gnt,
   input  logic          imem_rvalid,
   input  logic [31:0]   imem_rdata,
   output logic [31:0]   inst_id,
   output logic [31:0]   pc_id,
   output logic          inst_valid_id,
   output logic          misalign
);

   localparam int            PW      = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
   localparam int            CW      = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(FQ_DEPTH);

   logic [31:0]   r_pc;
   logic [31:0]   r_pc_q   [FQ_DEPTH];
   logic [31:0]   r_inst_q [FQ_DEPTH];
   logic [PW-1:0] r_rd_ptr;
   logic [PW-1:0] r_gnt_ptr;
   logic [PW-1:0] r_rsp_ptr;
   logic [CW-1:0] r_occ;
   logic [CW-1:0] r_outst;
   logic [CW-1:0] r_drop;

   logic          w_redirect;
   logic [31:0]   w_target_raw;
   logic [31:0]   w_target;
   logic          w_req;
   logic          w_acc;
   logic          w_valid;
   logic          w_enq;
   logic          w_drop_dec;
   logic          w_deq;

   always_comb begin
      w_target_raw = RESET_VEC;
      case (pc_sel)
         2'd1:    w_target_raw = alu_out;
         2'd2:    w_target_raw = bp_target;
         default: w_target_raw = RESET_VEC;
      endcase
   end

   assign w_redirect = (pc_sel != 2'd0);
   assign w_target   = {w_target_raw[31:2], 2'b00};

   // r_outst counts every in-flight request, including those marked for drop,
   // so a granted request always finds a free slot when its data returns.
   assign w_req      = !rst && !w_redirect && ((r_occ + r_outst) < DEPTH_C) &&
                       (r_drop != DEPTH_C);
   assign w_acc      = w_req && imem_gnt;
   assign w_valid    = !rst && !w_redirect && (r_occ != '0);
   assign w_enq      = imem_rvalid && !w_redirect && (r_drop == '0);
   assign w_drop_dec = imem_rvalid && !w_redirect && (r_drop != '0);
   assign w_deq      = w_valid && !stall_id;

   assign imem_req      = w_req;
   assign imem_addr     = r_pc[AW-1:0];
   assign inst_valid_id = w_valid;
   assign inst_id       = w_valid ? r_inst_q[r_rd_ptr] : NOP_INST;
   assign pc_id         = r_pc_q[r_rd_ptr];
   assign misalign      = !rst && w_redirect && (w_target_raw[1:0] != 2'b00);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pc      <= RESET_VEC;
         r_rd_ptr  <= '0;
         r_gnt_ptr <= '0;
         r_rsp_ptr <= '0;
         r_occ     <= '0;
         r_outst   <= '0;
         r_drop    <= '0;
      end else begin
         r_outst <= r_outst + CW'(w_acc) - CW'(imem_rvalid);
         if (w_redirect) begin
            r_pc      <= w_target;
            r_rd_ptr  <= '0;
            r_gnt_ptr <= '0;
            r_rsp_ptr <= '0;
            r_occ     <= '0;
            // Everything still in flight after this edge belongs to the old path.
            r_drop    <= r_outst + CW'(w_acc) - CW'(imem_rvalid);
         end else begin
            if (w_acc) begin
               r_pc      <= r_pc + 32'd4;
               r_gnt_ptr <= r_gnt_ptr + PW'(1);
            end
            if (w_enq) r_rsp_ptr <= r_rsp_ptr + PW'(1);
            if (w_deq) r_rd_ptr  <= r_rd_ptr + PW'(1);
            if (w_drop_dec) r_drop <= r_drop - CW'(1);
            r_occ <= r_occ + CW'(w_enq) - CW'(w_deq);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < FQ_DEPTH; i++) r_pc_q[i] <= RESET_VEC;
      end else if (w_acc) begin
         r_pc_q[r_gnt_ptr] <= r_pc;
      end
   end

   always_ff @(posedge clk) begin
      if (w_enq) r_inst_q[r_rsp_ptr] <= imem_rdata;
   end

endmodule

// File: tb/tb_ama_riscv_fetch_unit.sv
// Bench for ama_riscv_fetch_unit: IMEM responder plus a queue-level model of
// the instruction stream ID must see, with directed literal scenarios.
module tb_ama_riscv_fetch_unit;

   localparam int          AW        = 14;
   localparam int          FQ_DEPTH  = 4;
   localparam logic [31:0] RESET_VEC = 32'h0;
   localparam logic [31:0] NOP_INST  = 32'h0000_0013;

   logic          clk = 1'b0;
   logic          rst;
   logic [1:0]    pc_sel;
   logic [31:0]   alu_out;
   logic [31:0]   bp_target;
   logic          stall_id;
   logic          imem_req;
   logic [AW-1:0] imem_addr;
   logic          imem_gnt;
   logic          imem_rvalid;
   logic [31:0]   imem_rdata;
   logic [31:0]   inst_id;
   logic [31:0]   pc_id;
   logic          inst_valid_id;
   logic          misalign;

   ama_riscv_fetch_unit #(
      .RESET_VEC(RESET_VEC), .AW(AW), .FQ_DEPTH(FQ_DEPTH), .NOP_INST(NOP_INST)
   ) dut (
      .clk(clk), .rst(rst), .pc_sel(pc_sel), .alu_out(alu_out),
      .bp_target(bp_target), .stall_id(stall_id), .imem_req(imem_req),
      .imem_addr(imem_addr), .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid),
      .imem_rdata(imem_rdata), .inst_id(inst_id), .pc_id(pc_id),
      .inst_valid_id(inst_valid_id), .misalign(misalign)
   );

   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_pass   = 0;
   int          cyc      = 0;
   int          lat_min  = 0;
   int          lat_max  = 0;
   logic [31:0] exp_q[$];
   logic [31:0] pend_pc[$];
   int          pend_rdy[$];
   logic [31:0] dlv_log[$];
   logic [31:0] m_pc;
   int          m_drop;

   function automatic logic [31:0] inst_of(input logic [AW-1:0] a);
      logic [31:0] x;
      x = 32'(a);
      return (x * 32'h9E37_79B9) ^ 32'h5A5A_0000;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic model_reset();
      exp_q.delete();
      pend_pc.delete();
      pend_rdy.delete();
      m_pc   = RESET_VEC;
      m_drop = 0;
   endtask

   // Check this cycle's outputs, then advance the model across the coming edge.
   task automatic model_step();
      logic        redirect;
      logic [31:0] tgt;
      logic [31:0] head;
      logic [31:0] pc_r;
      logic        e_req, e_valid, e_mis, acc;
      redirect = (pc_sel != 2'd0);
      tgt      = (pc_sel == 2'd1) ? alu_out : (pc_sel == 2'd2) ? bp_target : RESET_VEC;
      e_mis    = redirect && (tgt[1:0] != 2'b00);
      e_req    = !redirect && ((exp_q.size() + pend_pc.size()) < FQ_DEPTH);
      e_valid  = !redirect && (exp_q.size() > 0);
      chk("imem_req", 32'(imem_req), 32'(e_req));
      chk("inst_valid", 32'(inst_valid_id), 32'(e_valid));
      chk("misalign", 32'(misalign), 32'(e_mis));
      if (e_req) chk("imem_addr", 32'(imem_addr), 32'(m_pc[AW-1:0]));
      if (e_valid) begin
         head = exp_q[0];
         chk("pc_id", pc_id, head);
         chk("inst_id", inst_id, inst_of(head[AW-1:0]));
      end else begin
         chk("inst_nop", inst_id, NOP_INST);
      end
      acc = imem_req && imem_gnt;
      if (imem_rvalid && pend_pc.size() > 0) begin
         pc_r = pend_pc.pop_front();
         void'(pend_rdy.pop_front());
         if (!redirect) begin
            if (m_drop > 0) m_drop--;
            else exp_q.push_back(pc_r);
         end
      end
      if (e_valid && !stall_id) begin
         dlv_log.push_back(pc_id);
         void'(exp_q.pop_front());
      end
      if (acc) begin
         pend_pc.push_back(m_pc);
         pend_rdy.push_back(cyc + 1 + int'($urandom_range(lat_max, lat_min)));
      end
      if (redirect) begin
         exp_q.delete();
         m_drop = pend_pc.size();
         m_pc   = {tgt[31:2], 2'b00};
      end else if (acc) begin
         m_pc = m_pc + 32'd4;
      end
   endtask

   task automatic cycle(input logic [1:0] sel, input logic [31:0] tgt,
                        input logic stl, input logic g);
      logic [31:0] a;
      @(posedge clk);
      #1;
      pc_sel    = sel;
      alu_out   = tgt;
      bp_target = ~tgt;
      stall_id  = stl;
      imem_gnt  = g;
      imem_rvalid = (pend_pc.size() > 0) && (pend_rdy[0] <= cyc);
      if (imem_rvalid) begin
         a = pend_pc[0];
         imem_rdata = inst_of(a[AW-1:0]);
      end else begin
         imem_rdata = $urandom;
      end
      @(negedge clk);
      model_step();
      cyc++;
   endtask

   task automatic rand_cycles(input int n);
      logic [1:0] sel;
      for (int i = 0; i < n; i++) begin
         sel = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(3, 1)) : 2'd0;
         cycle(sel, $urandom, ($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 7));
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_req"}, 32'(imem_req), 32'h0);
      chk({tag, "_valid"}, 32'(inst_valid_id), 32'h0);
      chk({tag, "_inst"}, inst_id, NOP_INST);
      chk({tag, "_pc"}, pc_id, RESET_VEC);
      chk({tag, "_mis"}, 32'(misalign), 32'h0);
   endtask

   initial begin
      rst = 1'b1; pc_sel = 2'd1; alu_out = 32'h102; bp_target = 32'h0;
      stall_id = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      pc_sel = 2'd0;
      @(posedge clk);
      #1 rst = 1'b0;

      // Streaming from RESET_VEC with single-cycle IMEM latency.
      for (int k = 0; k < 6; k++) begin
         cycle(2'd0, 32'h0, 1'b0, 1'b1);
         chk("seq_addr", 32'(imem_addr), 32'(4 * k));
         if (k >= 2) begin
            chk("seq_valid", 32'(inst_valid_id), 32'h1);
            chk("seq_pc", pc_id, 32'(4 * (k - 2)));
         end
      end

      // ID stall: fetching must back off once the queue plus in-flight is full.
      for (int k = 0; k < 6; k++) begin
         cycle(2'd0, 32'h0, 1'b1, 1'b1);
         if (k == 5) begin
            chk("stall_req_low", 32'(imem_req), 32'h0);
            chk("stall_valid", 32'(inst_valid_id), 32'h1);
         end
      end
      repeat (8) cycle(2'd0, 32'h0, 1'b0, 1'b1);

      // Redirect with two requests in flight.
      lat_min = 1; lat_max = 1;
      repeat (4) cycle(2'd0, 32'h0, 1'b0, 1'b1);
      dlv_log.delete();
      cycle(2'd1, 32'h100, 1'b0, 1'b1);
      chk("redir_req_low", 32'(imem_req), 32'h0);
      chk("redir_valid_low", 32'(inst_valid_id), 32'h0);
      lat_min = 0; lat_max = 0;
      repeat (6) cycle(2'd0, 32'h0, 1'b0, 1'b1);
      chk("redir_cnt", 32'(dlv_log.size() >= 2), 32'h1);
      chk("redir_pc0", dlv_log[0], 32'h100);
      chk("redir_pc1", dlv_log[1], 32'h104);

      // Misaligned redirect target.
      dlv_log.delete();
      cycle(2'd1, 32'h102, 1'b0, 1'b1);
      chk("mis_pulse", 32'(misalign), 32'h1);
      cycle(2'd0, 32'h0, 1'b0, 1'b1);
      chk("mis_clear", 32'(misalign), 32'h0);
      chk("mis_addr", 32'(imem_addr), 32'h100);
      repeat (4) cycle(2'd0, 32'h0, 1'b0, 1'b1);
      chk("mis_pc0", dlv_log[0], 32'h100);

      // 32-bit PC wrap-around.
      dlv_log.delete();
      cycle(2'd1, 32'hFFFF_FFFC, 1'b0, 1'b1);
      cycle(2'd0, 32'h0, 1'b0, 1'b1);
      chk("wrap_addr0", 32'(imem_addr), 32'h3FFC);
      cycle(2'd0, 32'h0, 1'b0, 1'b1);
      chk("wrap_addr1", 32'(imem_addr), 32'h0);
      repeat (4) cycle(2'd0, 32'h0, 1'b0, 1'b1);
      chk("wrap_cnt", 32'(dlv_log.size() >= 2), 32'h1);
      chk("wrap_pc0", dlv_log[0], 32'hFFFF_FFFC);
      chk("wrap_pc1", dlv_log[1], 32'h0);

      // Branch-predictor and start-address selects.
      dlv_log.delete();
      cycle(2'd2, ~32'h200, 1'b0, 1'b1);
      repeat (4) cycle(2'd0, 32'h0, 1'b0, 1'b1);
      chk("bp_pc0", dlv_log[0], 32'h200);
      dlv_log.delete();
      cycle(2'd3, 32'h5554, 1'b0, 1'b1);
      repeat (4) cycle(2'd0, 32'h0, 1'b0, 1'b1);
      chk("start_pc0", dlv_log[0], RESET_VEC);

      // Randomized traffic with variable IMEM latency.
      lat_min = 0; lat_max = 3;
      rand_cycles(3000);

      // Asynchronous reset between edges.
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      check_reset_outputs("async_rst");
      pc_sel = 2'd0; stall_id = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      rand_cycles(1000);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/ama_riscv_fetch_unit.md
AMA_RISCV_FETCH_UNIT -- requirements
Module: ama_riscv_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_VEC, default 32'h0, PC loaded on reset and on start-address select.
REQ-002 SHALL have parameter AW, default 14, IMEM byte-address width.
REQ-003 SHALL have parameter FQ_DEPTH, default 4, fetch queue entries (power of 2, 2..16).
REQ-004 SHALL have parameter NOP_INST, default 32'h0000_0013, instruction presented when no valid instruction.
REQ-005 SHALL have ports, clock and reset first:
- clk  input  1  core clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- pc_sel  input  2  0=INC4, 1=ALU, 2=BP, 3=START_ADDR.
- alu_out  input  32  redirect target for pc_sel=1.
- bp_target  input  32  predicted target for pc_sel=2.
- stall_id  input  1  ID stage cannot accept an instruction.
- imem_req  output  1  fetch request valid.
- imem_addr  output  AW  request byte address, pc[AW-1:0].
- imem_gnt  input  1  request accepted this cycle.
- imem_rvalid  input  1  read data valid; responses return in request order.
- imem_rdata  input  32  read data.
- inst_id  output  32  instruction to ID.
- pc_id  output  32  PC of inst_id.
- inst_valid_id  output  1  inst_id is real.
- misalign  output  1  one-cycle pulse on misaligned redirect target.

Function
REQ-006 SHALL hold fetch PC register pc; request handshake completes when imem_req && imem_gnt.
REQ-007 SHALL assert imem_req only when occupancy + outstanding < FQ_DEPTH; hence every response always has a free queue slot.
REQ-008 SHALL advance pc by 4 on each accepted request when pc_sel=0 (32-bit wrap-around, 32'hFFFF_FFFC -> 32'h0).
REQ-009 SHALL treat pc_sel!=0 as redirect: pc loads the target (alu_out, bp_target, or RESET_VEC) the next edge, overriding any increment that cycle.
REQ-010 SHALL on redirect clear the queue and set drop count = outstanding requests (including one accepted in the same cycle); the next drop-count responses SHALL be discarded.
REQ-011 SHALL ignore a response arriving in the redirect cycle (counted in drop count, not enqueued).
REQ-012 SHALL hold imem_req low in the redirect cycle; requests for the new PC start the following cycle.
REQ-013 SHALL, on target[1:0]!=0, force target[1:0]=2'b00 and pulse misalign for that cycle.
REQ-014 SHALL enqueue each non-dropped response with its request PC (PC FIFO of FQ_DEPTH entries, written on grant).
REQ-015 SHALL drive inst_id/pc_id from queue head combinationally with inst_valid_id=1 when queue non-empty and no redirect this cycle; otherwise inst_id=NOP_INST, inst_valid_id=0, pc_id=head PC.
REQ-016 SHALL dequeue when inst_valid_id && !stall_id; simultaneous enqueue and dequeue SHALL keep occupancy unchanged.
REQ-017 SHALL have zero-cycle bypass latency none: a response is visible on inst_id the cycle after imem_rvalid.
REQ-018 SHALL keep pointers modulo FQ_DEPTH with wrap; occupancy counter width clog2(FQ_DEPTH)+1.
REQ-019 SHALL not assert imem_req while drop count equals FQ_DEPTH.

Reset
REQ-020 SHALL on rst (asynchronous assertion) set pc=RESET_VEC, queue empty, outstanding=0, drop count=0.
REQ-021 SHALL during and after reset drive imem_req=0, inst_id=NOP_INST, inst_valid_id=0, misalign=0, pc_id=RESET_VEC.
REQ-022 SHALL start requesting at RESET_VEC the first edge after rst deasserts; reset mid-transaction SHALL discard all in-flight responses arriving after deassertion? No -- IMEM is reset together; none expected.

Verification
REQ-023 Reset release, gnt=1, rvalid one cycle later -> addresses 0x0,0x4,0x8...; inst_valid_id from cycle 2; pc_id matches.
REQ-024 stall_id held 6 cycles, FQ_DEPTH=4 -> imem_req drops after 4 in flight/queued; no data lost; order preserved after release.
REQ-025 Redirect pc_sel=1, alu_out=0x100 with 2 outstanding -> 2 responses dropped; next inst_valid_id shows pc_id=0x100.
REQ-026 Redirect alu_out=0x102 -> misalign pulses 1 cycle; fetch at 0x100.
REQ-027 pc=0xFFFF_FFFC sequential -> next request pc 0x0.
REQ-028 Async rst asserted mid-stream between edges -> outputs reset immediately, imem_req=0, queue empty.
